lwe_decrypt: RTL and testbench

Serial LWE decryption stage that sits directly downstream of `homomorphic_add`. It takes a result ciphertext (b, a[1..DIMENSION]) and a secret key, accumulates ⟨a, s⟩ mod q over DIMENSION cycles, and scales b − ⟨a, s⟩ from modulus q to modulus p with rounding. It returns the plaintext over a valid/ready handshake, which closes the add → decrypt verification loop in hardware.

---
 rtl/lwe_decrypt_pkg.sv | 18 +
 rtl/lwe_decrypt_mod_q_mac.sv | 24 ++
 rtl/lwe_decrypt.sv | 150 +++++++++++++++
 tb/tb_lwe_decrypt.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwe_decrypt_pkg.sv
// lwe_decrypt_pkg: shared default parameters and FSM state encoding for the
// LWE pipeline stages (homomorphic_add, encrypt, decrypt).
package lwe_decrypt_pkg;

    localparam int unsigned DEF_PLAINTEXT_MODULUS  = 64;
    localparam int unsigned DEF_PLAINTEXT_WIDTH    = 6;
    localparam int unsigned DEF_DIMENSION          = 1;
    localparam int unsigned DEF_CIPHERTEXT_MODULUS = 1024;
    localparam int unsigned DEF_CIPHERTEXT_WIDTH   = 21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/lwe_decrypt_mod_q_mac.sv
// mod_q_mac: combinational (acc + a*s) mod q for power-of-two q = 2**Q_LOG.
// Ports:
//   acc      - running accumulator, Q_LOG bits
//   a, s     - ciphertext and key elements, already reduced to Q_LOG bits
//   result_c - (acc + a*s) mod q
module mod_q_mac #(
    parameter int unsigned Q_LOG = 10
) (
    input  logic [Q_LOG-1:0] acc,
    input  logic [Q_LOG-1:0] a,
    input  logic [Q_LOG-1:0] s,
    output logic [Q_LOG-1:0] result_c
);

    logic [2*Q_LOG-1:0] prod;
    logic [Q_LOG-1:0]   prod_lo;
    logic [Q_LOG-1:0]   unused_prod_hi;

    // Full-width product; mod q is just keeping the low Q_LOG bits.
    assign prod = (2*Q_LOG)'(a) * (2*Q_LOG)'(s);
    assign {unused_prod_hi, prod_lo} = prod;
    assign result_c = acc + prod_lo;

endmodule

// File: rtl/lwe_decrypt.sv
// lwe_decrypt: serial LWE decryption. Accumulates <a,s> mod q over DIMENSION
// cycles, then rounds (b - <a,s>) from modulus q down to modulus p.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - input handshake (in_ready high only when idle)
//   ciphertext            - {a[n], ..., a[1], b}, CIPHERTEXT_WIDTH per element
//   secret_key            - {s[n], ..., s[1]}, CIPHERTEXT_WIDTH per element
//   out_valid / out_ready - output handshake
//   plaintext             - decrypted message, held while out_valid
module lwe_decrypt
    import lwe_decrypt_pkg::*;
#(
    parameter int unsigned PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
    parameter int unsigned PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
    parameter int unsigned DIMENSION          = DEF_DIMENSION,
    parameter int unsigned CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
    parameter int unsigned CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0] ciphertext,
    input  logic [DIMENSION*CIPHERTEXT_WIDTH-1:0]     secret_key,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]                plaintext
);

    localparam int unsigned Q_LOG   = $clog2(CIPHERTEXT_MODULUS);
    localparam int unsigned P_LOG   = $clog2(PLAINTEXT_MODULUS);
    localparam int unsigned CW      = CIPHERTEXT_WIDTH;
    localparam int unsigned IDX_W   = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam int unsigned SLOTS   = 1 << IDX_W;
    localparam int unsigned SCALE_W = Q_LOG + P_LOG + 1;

    localparam logic [SCALE_W-1:0] HALF_Q   = SCALE_W'(CIPHERTEXT_MODULUS / 2);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIMENSION - 1);

    state_e state;
    state_e next_state;
    logic   in_ready_d;
    logic   out_valid_d;

    logic [Q_LOG-1:0]   b_q;
    logic [Q_LOG-1:0]   a_q   [SLOTS];
    logic [Q_LOG-1:0]   s_q   [SLOTS];
    logic [Q_LOG-1:0]   a_in  [SLOTS];
    logic [Q_LOG-1:0]   s_in  [SLOTS];
    logic [Q_LOG-1:0]   acc;
    logic [Q_LOG-1:0]   acc_next;
    logic [IDX_W-1:0]   idx;
    logic [Q_LOG-1:0]   diff;
    logic [SCALE_W-1:0] scaled;
    logic               unused_bits;

    // Slice each element down to its low Q_LOG bits; pad slots beyond n with zero.
    for (genvar g = 0; g < SLOTS; g++) begin : g_unpack
        if (g < DIMENSION) begin : g_live
            assign a_in[g] = ciphertext[(g+1)*CW +: Q_LOG];
            assign s_in[g] = secret_key[g*CW +: Q_LOG];
        end else begin : g_pad
            assign a_in[g] = '0;
            assign s_in[g] = '0;
        end
    end

    // Upper storage bits and the fractional/overflow bits of the scaled value are discarded.
    assign unused_bits = ^{ciphertext, secret_key, scaled};

    mod_q_mac #(.Q_LOG(Q_LOG)) u_mac (
        .acc      (acc),
        .a        (a_q[idx]),
        .s        (s_q[idx]),
        .result_c (acc_next)
    );

    // Round(d * p / q) mod p: shift up by P_LOG, add q/2, take bits above Q_LOG.
    assign diff   = b_q - acc;
    assign scaled = (SCALE_W'(diff) << P_LOG) + HALF_Q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (in_valid) next_state = ST_MAC;
            ST_MAC:   if (idx == LAST_IDX) next_state = ST_SCALE;
            ST_SCALE: next_state = ST_DONE;
            ST_DONE:  if (out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (next_state == ST_IDLE) in_ready_d = 1'b1;
        if (next_state == ST_DONE) out_valid_d = 1'b1;
    end

    // Handshake outputs, accumulator, index and result
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            plaintext <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                end
                ST_SCALE: plaintext <= PLAINTEXT_WIDTH'(scaled[Q_LOG +: P_LOG]);
                default: ;
            endcase
        end
    end

    // Operand capture; no reset needed, only loaded on acceptance
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid && !rst) begin
            b_q <= ciphertext[0 +: Q_LOG];
            for (int i = 0; i < int'(SLOTS); i++) begin
                a_q[i] <= a_in[i];
                s_q[i] <= s_in[i];
            end
        end
    end

endmodule

// File: tb/tb_lwe_decrypt.sv
// tb_lwe_decrypt: self-checking bench for lwe_decrypt with one n=1 and one n=4
// instance (q=1024, p=64). Expected plaintexts go into a per-instance queue when
// a ciphertext is accepted and are popped when out_valid appears.
module tb_lwe_decrypt;

    localparam int CW = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic         ordy;
    logic         iv1, ir1, ov1;
    logic         iv4, ir4, ov4;
    logic [41:0]  ct1;
    logic [20:0]  sk1;
    logic [104:0] ct4;
    logic [83:0]  sk4;
    logic [5:0]   pt1, pt4;

    int comps = 0;
    int mism  = 0;
    logic [5:0] sb1[$];
    logic [5:0] sb4[$];

    always #5 clk = ~clk;

    lwe_decrypt #(.DIMENSION(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .ciphertext(ct1),
        .secret_key(sk1), .out_valid(ov1), .out_ready(ordy), .plaintext(pt1)
    );

    lwe_decrypt #(.DIMENSION(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .ciphertext(ct4),
        .secret_key(sk4), .out_valid(ov4), .out_ready(ordy), .plaintext(pt4)
    );

    function automatic logic get_ir(input bit big);
        return big ? ir4 : ir1;
    endfunction
    function automatic logic get_ov(input bit big);
        return big ? ov4 : ov1;
    endfunction
    function automatic logic [5:0] get_pt(input bit big);
        return big ? pt4 : pt1;
    endfunction

    // Present one ciphertext for one cycle; it must be accepted.
    task automatic accept(input bit big, input int b, input int a0, input int a1,
                          input int a2, input int a3, input int s0, input int s1,
                          input int s2, input int s3, input logic [5:0] exp_m,
                          input string name);
        @(negedge clk);
        comps++;
        if (get_ir(big) !== 1'b1) begin
            mism++;
            $display("FAIL %s_in_ready: got %b expected 1", name, get_ir(big));
        end
        if (big) begin
            ct4 = {CW'(a3), CW'(a2), CW'(a1), CW'(a0), CW'(b)};
            sk4 = {CW'(s3), CW'(s2), CW'(s1), CW'(s0)};
            iv4 = 1'b1;
            sb4.push_back(exp_m);
        end else begin
            ct1 = {CW'(a0), CW'(b)};
            sk1 = CW'(s0);
            iv1 = 1'b1;
            sb1.push_back(exp_m);
        end
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv4 = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and plaintext against the scoreboard.
    task automatic wait_valid(input bit big, input int exp_lat, input string name,
                              output logic [5:0] exp_m);
        int lat = 0;
        bit seen = 0;
        logic [5:0] e;
        if (big) e = sb4.pop_front();
        else     e = sb1.pop_front();
        exp_m = e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (get_ov(big)) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        comps++;
        if (!seen || lat != exp_lat) begin
            mism++;
            $display("FAIL %s_latency: got %0d (seen=%0d) expected %0d", name, lat, seen, exp_lat);
        end
        comps++;
        if (get_pt(big) !== e) begin
            mism++;
            $display("FAIL %s_plaintext: got %0d expected %0d", name, get_pt(big), e);
        end
    endtask

    // One transfer with out_ready, then the block must be idle again.
    task automatic release_out(input bit big, input string name);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        @(negedge clk);
        comps++;
        if (get_ir(big) !== 1'b1 || get_ov(big) !== 1'b0) begin
            mism++;
            $display("FAIL %s_release: got in_ready=%b out_valid=%b expected 1/0",
                     name, get_ir(big), get_ov(big));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iv1 = 0; iv4 = 0; ordy = 0;
        ct1 = '0; sk1 = '0; ct4 = '0; sk4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        comps++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0 || pt1 !== 6'd0) begin
            mism++;
            $display("FAIL reset_n1: got ir=%b ov=%b pt=%0d expected 1/0/0", ir1, ov1, pt1);
        end
        comps++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0 || pt4 !== 6'd0) begin
            mism++;
            $display("FAIL reset_n4: got ir=%b ov=%b pt=%0d expected 1/0/0", ir4, ov4, pt4);
        end
    endtask

    task automatic test_basic();
        logic [5:0] e;
        accept(0, 383, 100, 0, 0, 0, 3, 0, 0, 0, 6'd5, "basic");
        wait_valid(0, 2, "basic", e);
        release_out(0, "basic");
    endtask

    task automatic test_wrap();
        logic [5:0] e;
        // Upper storage bits of a set to check they are ignored.
        accept(0, 458, 500 | (1 << 15), 0, 0, 0, 3, 0, 0, 0, 6'd63, "wrap");
        wait_valid(0, 2, "wrap", e);
        release_out(0, "wrap");
    endtask

    task automatic test_neg_noise();
        logic [5:0] e;
        accept(0, 25, 10, 0, 0, 0, 3, 0, 0, 0, 6'd0, "negnoise");
        wait_valid(0, 2, "negnoise", e);
        release_out(0, "negnoise");
    endtask

    task automatic test_backpressure();
        logic [5:0] e;
        int bad = 0;
        // m=40, e=+1: a*s = 63, b = 63 + 640 + 1
        accept(0, 704, 7, 0, 0, 0, 9, 0, 0, 0, 6'd40, "bp");
        wait_valid(0, 2, "bp", e);
        for (int i = 0; i < 10; i++) begin
            iv1 = 1'b1;
            ct1 = {CW'(i * 37), CW'(i * 11)};
            sk1 = CW'(i + 1);
            @(posedge clk);
            @(negedge clk);
            if (ov1 !== 1'b1 || pt1 !== e || ir1 !== 1'b0) bad++;
        end
        iv1 = 1'b0;
        comps++;
        if (bad != 0) begin
            mism++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        release_out(0, "bp");
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov1 !== 1'b0 || ir1 !== 1'b1) bad++;
        end
        comps++;
        if (bad != 0) begin
            mism++;
            $display("FAIL bp_no_queue: got %0d busy cycles expected 0", bad);
        end
    endtask

    task automatic test_dim4();
        logic [5:0] e;
        accept(1, 412, 10, 20, 30, 40, 1, 2, 3, 4, 6'd7, "dim4");
        wait_valid(1, 5, "dim4", e);
        release_out(1, "dim4");
    endtask

    task automatic test_reset_mid_mac();
        logic [5:0] e;
        accept(1, 412, 10, 20, 30, 40, 1, 2, 3, 4, 6'd7, "rstmac");
        @(negedge clk);
        rst = 1'b1;
        iv4 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv4 = 1'b0;
        sb4.delete();
        @(negedge clk);
        comps++;
        if (ov4 !== 1'b0 || pt4 !== 6'd0 || ir4 !== 1'b1) begin
            mism++;
            $display("FAIL rstmac_state: got ov=%b pt=%0d ir=%b expected 0/0/1", ov4, pt4, ir4);
        end
        @(negedge clk);
        comps++;
        if (ir4 !== 1'b1) begin
            mism++;
            $display("FAIL rstmac_not_accepted: got in_ready=%b expected 1", ir4);
        end
        // <a,s> = 70, m=33, e=+2: b = 70 + 528 + 2
        accept(1, 600, 5, 6, 7, 8, 1, 2, 3, 4, 6'd33, "rstmac_fresh");
        wait_valid(1, 5, "rstmac_fresh", e);
        release_out(1, "rstmac_fresh");
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        for (int k = 0; k < 6; k++) begin
            int a, s, m, ns, b;
            a  = int'($urandom_range(0, 1023));
            s  = int'($urandom_range(0, 1023));
            m  = int'($urandom_range(0, 63));
            ns = int'($urandom_range(0, 14)) - 7;
            b  = (a * s + m * 16 + ns) % 1024;
            if (b < 0) b += 1024;
            // Junk in the unused storage bits above bit 9.
            a = a | (int'($urandom_range(0, 2047)) << 10);
            b = b | (int'($urandom_range(0, 2047)) << 10);
            accept(0, b, a, 0, 0, 0, s, 0, 0, 0, 6'(m), "b2b");
            wait_valid(0, 2, "b2b", e);
            release_out(0, "b2b");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_neg_noise();
        test_backpressure();
        test_dim4();
        test_reset_mid_mac();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, mism);
        $finish;
    end

endmodule
